// File: rtl/apb_lite_master6.sv
// apb_lite_master6
// APB initiator: converts a valid/ready command stream into APB transfers
// and returns one response pulse per accepted command.
//
// Optional feature macro: APB_MASTER_PREADY_EN
//   defined   -> pready6/pslverr6 ports exist, ACCESS stretches while
//                pready6=0, and a wait counter forces an error completion
//                once it reaches TIMEOUT.
//   undefined -> ACCESS is always one cycle and rsp_err6 is tied 0.
//
// Ports:
//   pclk6, n_p_reset6       clock / async active-low reset
//   cmd_valid6/cmd_ready6   command handshake
//   cmd_write6/addr6/wdata6 command payload
//   rsp_valid6/rdata6/err6  one-cycle response, data and error held after
//   psel6/penable6/pwrite6  APB control
//   paddr6/pwdata6/prdata6  APB address and data
//   pready6/pslverr6        APB slave handshake (feature only)
module apb_lite_master6 #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk6,
  input  logic              n_p_reset6,
  input  logic              cmd_valid6,
  output logic              cmd_ready6,
  input  logic              cmd_write6,
  input  logic [ADDR_W-1:0] cmd_addr6,
  input  logic [31:0]       cmd_wdata6,
  output logic              rsp_valid6,
  output logic [31:0]       rsp_rdata6,
  output logic              rsp_err6,
  output logic              psel6,
  output logic              penable6,
  output logic              pwrite6,
  output logic [ADDR_W-1:0] paddr6,
  output logic [31:0]       pwdata6,
`ifdef APB_MASTER_PREADY_EN
  input  logic              pready6,
  input  logic              pslverr6,
`endif
  input  logic [31:0]       prdata6
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e              state_q, state_d;
  logic                complete;
  logic                accept;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [31:0]         pwdata_q;
  logic                rspValid_q;
  logic [31:0]         rspRdata_q;
  logic [31:0]         capData;

  assign accept = cmd_valid6 & cmd_ready6;

`ifdef APB_MASTER_PREADY_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic             timedOut;
  logic             rspErr_q;

  // A late pready6 still wins over the timeout in the same cycle.
  assign timedOut = (state_q == ACCESS) && !pready6 && (waitCnt_q == CNT_W'(TIMEOUT));
  assign complete = (state_q == ACCESS) && (pready6 || timedOut);

  // Wait counter: cleared in SETUP, counts stalled ACCESS cycles.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (state_q == SETUP) begin
      waitCnt_d = '0;
    end else if ((state_q == ACCESS) && !complete) begin
      waitCnt_d = waitCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk6 or negedge n_p_reset6) begin
    if (!n_p_reset6) begin
      waitCnt_q <= '0;
      rspErr_q  <= 1'b0;
    end else begin
      waitCnt_q <= waitCnt_d;
      if (complete) begin
        rspErr_q <= timedOut | pslverr6;
      end
    end
  end

  assign rsp_err6 = rspErr_q;

  // Writes and timed-out transfers return zero data.
  always_comb begin
    capData = pwrite_q ? 32'h0 : prdata6;
    if (timedOut) begin
      capData = 32'h0;
    end
  end
`else
  assign complete = (state_q == ACCESS);
  assign rsp_err6 = 1'b0;

  // Writes return zero data.
  always_comb begin
    capData = pwrite_q ? 32'h0 : prdata6;
  end
`endif

  // State register.
  always_ff @(posedge pclk6 or negedge n_p_reset6) begin
    if (!n_p_reset6) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a command arriving in the completing ACCESS cycle goes
  // straight to SETUP so back-to-back transfers keep psel6 high.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid6) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (complete) state_d = cmd_valid6 ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; cmd_ready6 opens only when free.
  always_comb begin
    psel6      = (state_q != IDLE);
    penable6   = (state_q == ACCESS);
    cmd_ready6 = (state_q == IDLE) || complete;
  end

  // Command capture; pwdata holds its last value across reads.
  always_ff @(posedge pclk6 or negedge n_p_reset6) begin
    if (!n_p_reset6) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= 32'h0;
    end else if (accept) begin
      pwrite_q <= cmd_write6;
      paddr_q  <= cmd_addr6;
      if (cmd_write6) begin
        pwdata_q <= cmd_wdata6;
      end
    end
  end

  // Response: pulse the cycle after completion, data held until next one.
  always_ff @(posedge pclk6 or negedge n_p_reset6) begin
    if (!n_p_reset6) begin
      rspValid_q <= 1'b0;
      rspRdata_q <= 32'h0;
    end else begin
      rspValid_q <= complete;
      if (complete) begin
        rspRdata_q <= capData;
      end
    end
  end

  assign pwrite6    = pwrite_q;
  assign paddr6     = paddr_q;
  assign pwdata6    = pwdata_q;
  assign rsp_valid6 = rspValid_q;
  assign rsp_rdata6 = rspRdata_q;

endmodule
